// File: rtl/ervp_spi_responder_if.sv
// Byte-wide register-access port between the SPI responder (master side)
// and local register logic (slave side).
interface ervp_spi_responder_if #(
   parameter int BW_ADDR = 7
);
   logic               reg_wren;
   logic               reg_rden;
   logic [BW_ADDR-1:0] reg_addr;
   logic [7:0]         reg_wdata;
   logic [7:0]         reg_rdata;

   modport master (
      output reg_wren, reg_rden, reg_addr, reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_wren, reg_rden, reg_addr, reg_wdata,
      output reg_rdata
   );
endinterface

// File: rtl/ervp_spi_responder.sv
// SPI mode-0 responder: oversampled pins, command byte then write or read bursts
// mapped onto a byte-wide register-access port.
module ervp_spi_responder #(
   parameter int BW_ADDR  = 7,
   parameter int NUM_SYNC = 2
) (
   input  logic                 clk,
   input  logic                 rstnn,
   input  logic                 spi_sclk,
   input  logic                 spi_scs,
   input  logic                 spi_sdq0,
   output logic                 spi_sdq1,
   output logic                 spi_sdq1_oe,
   ervp_spi_responder_if.master reg_if,
   output logic                 frame_active,
   output logic                 frame_err
);
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_READ} state_t;

   localparam logic [BW_ADDR-1:0] ADDR_ONE = BW_ADDR'(1);

   logic [NUM_SYNC-1:0] sclk_sync_q, scs_sync_q, sdq0_sync_q, fill_q;
   logic                sclk_prev_q, scs_prev_q;
   logic                sclk_s, scs_s, sdq0_s, sync_ok;
   logic                sclk_rise, sclk_fall, scs_rise, scs_fall;

   state_t              state_q, state_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          rx_q, rx_d, rx_next;
   logic [7:0]          tx_q, tx_d;
   logic [BW_ADDR-1:0]  addr_q, addr_d;
   logic [BW_ADDR-1:0]  reg_addr_q, reg_addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                wren_q, wren_d, rden_q, rden_d;
   logic                load_q, load_d, err_q, err_d;
   logic                armed_q, armed_d;
   logic                byte_done;

   // fill_q marks when the chains hold genuine pin samples rather than reset values,
   // so an scs held low across reset release never arms the responder.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         sclk_sync_q <= '0;
         scs_sync_q  <= '1;
         sdq0_sync_q <= '0;
         fill_q      <= '0;
         sclk_prev_q <= 1'b0;
         scs_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[NUM_SYNC-2:0], spi_sclk};
         scs_sync_q  <= {scs_sync_q[NUM_SYNC-2:0], spi_scs};
         sdq0_sync_q <= {sdq0_sync_q[NUM_SYNC-2:0], spi_sdq0};
         fill_q      <= {fill_q[NUM_SYNC-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         scs_prev_q  <= scs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[NUM_SYNC-1];
   assign scs_s     = scs_sync_q[NUM_SYNC-1];
   assign sdq0_s    = sdq0_sync_q[NUM_SYNC-1];
   assign sync_ok   = fill_q[NUM_SYNC-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign scs_rise  = scs_s & ~scs_prev_q;
   assign scs_fall  = ~scs_s & scs_prev_q;

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         addr_q     <= '0;
         reg_addr_q <= '0;
         wdata_q    <= '0;
         wren_q     <= 1'b0;
         rden_q     <= 1'b0;
         load_q     <= 1'b0;
         err_q      <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         addr_q     <= addr_d;
         reg_addr_q <= reg_addr_d;
         wdata_q    <= wdata_d;
         wren_q     <= wren_d;
         rden_q     <= rden_d;
         load_q     <= load_d;
         err_q      <= err_d;
         armed_q    <= armed_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      addr_d     = addr_q;
      reg_addr_d = reg_addr_q;
      wdata_d    = wdata_q;
      wren_d     = 1'b0;
      rden_d     = 1'b0;
      load_d     = rden_q;
      err_d      = 1'b0;
      armed_d    = armed_q | (sync_ok & scs_s);
      rx_next    = {rx_q[6:0], sdq0_s};
      byte_done  = 1'b0;

      // Read data arrives one clk after the strobe cycle.
      if (load_q) tx_d = reg_if.reg_rdata;

      case (state_q)
         ST_IDLE: begin
            if (scs_fall && armed_q) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               rx_d      = '0;
            end
         end
         default: begin
            if (scs_rise) begin
               // Deselect outranks any simultaneous sclk edge; partial bytes are dropped.
               state_d   = ST_IDLE;
               err_d     = (bit_cnt_q != 3'd0);
               bit_cnt_d = '0;
            end else begin
               if (sclk_rise) begin
                  rx_d      = rx_next;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  byte_done = (bit_cnt_q == 3'd7);
               end
               // A freshly loaded byte keeps its MSB on the line until the next first rise.
               if (sclk_fall && state_q == ST_READ && bit_cnt_q != 3'd0)
                  tx_d = {tx_q[6:0], 1'b0};
               if (byte_done) begin
                  case (state_q)
                     ST_CMD: begin
                        if (rx_next[7]) begin
                           state_d    = ST_READ;
                           rden_d     = 1'b1;
                           reg_addr_d = rx_next[BW_ADDR-1:0];
                           addr_d     = rx_next[BW_ADDR-1:0] + ADDR_ONE;
                        end else begin
                           state_d = ST_WRITE;
                           addr_d  = rx_next[BW_ADDR-1:0];
                        end
                     end
                     ST_WRITE: begin
                        wren_d     = 1'b1;
                        reg_addr_d = addr_q;
                        wdata_d    = rx_next;
                        addr_d     = addr_q + ADDR_ONE;
                     end
                     default: begin
                        rden_d     = 1'b1;
                        reg_addr_d = addr_q;
                        addr_d     = addr_q + ADDR_ONE;
                     end
                  endcase
               end
            end
         end
      endcase
   end

   assign reg_if.reg_wren  = wren_q;
   assign reg_if.reg_rden  = rden_q;
   assign reg_if.reg_addr  = reg_addr_q;
   assign reg_if.reg_wdata = wdata_q;
   assign spi_sdq1         = (state_q == ST_READ) ? tx_q[7] : 1'b0;
   assign spi_sdq1_oe      = armed_q & ~scs_s;
   assign frame_active     = (state_q != ST_IDLE);
   assign frame_err        = err_q;
endmodule

// File: tb/tb_ervp_spi_responder.sv
// Directed and randomized-burst bench for ervp_spi_responder with a small register-bank
// model returning rdata = 2*addr+1.
module tb_ervp_spi_responder;
   localparam int BW_ADDR = 7;

   logic clk = 1'b0;
   logic rstnn = 1'b0;
   logic spi_sclk = 1'b0, spi_scs = 1'b1, spi_sdq0 = 1'b0;
   logic spi_sdq1, spi_sdq1_oe, frame_active, frame_err;
   logic [20:0] outs;

   ervp_spi_responder_if #(.BW_ADDR(BW_ADDR)) rif ();

   ervp_spi_responder #(.BW_ADDR(BW_ADDR), .NUM_SYNC(2)) dut (
      .clk          (clk),
      .rstnn        (rstnn),
      .spi_sclk     (spi_sclk),
      .spi_scs      (spi_scs),
      .spi_sdq0     (spi_sdq0),
      .spi_sdq1     (spi_sdq1),
      .spi_sdq1_oe  (spi_sdq1_oe),
      .reg_if       (rif),
      .frame_active (frame_active),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   assign outs = {spi_sdq1, spi_sdq1_oe, rif.reg_wren, rif.reg_rden, rif.reg_addr,
                  rif.reg_wdata, frame_active, frame_err};

   // Register bank model: registered read of 2*addr+1.
   always @(posedge clk) if (rif.reg_rden) rif.reg_rdata <= {rif.reg_addr, 1'b1};

   int npass = 0, ntotal = 0;
   int wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
   int err_cnt = 0, both_cnt = 0, sdq1_bad = 0;
   bit saw_active = 0, saw_oe = 0, sdq1_must_be_zero = 0;
   int half = 6;
   logic [7:0] mosi [8];
   logic [7:0] miso [8];

   always @(negedge clk) begin
      if (rif.reg_wren) begin
         wr_addr_q.push_back(int'(rif.reg_addr));
         wr_data_q.push_back(int'(rif.reg_wdata));
      end
      if (rif.reg_rden) rd_addr_q.push_back(int'(rif.reg_addr));
      if (rif.reg_wren && rif.reg_rden) both_cnt++;
      if (frame_err) err_cnt++;
      if (frame_active) saw_active = 1;
      if (spi_sdq1_oe) saw_oe = 1;
      if (sdq1_must_be_zero && spi_sdq1) sdq1_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntotal++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else npass++;
   endtask

   function automatic int wr_a(input int i);
      return (i < wr_addr_q.size()) ? wr_addr_q[i] : -1;
   endfunction
   function automatic int wr_d(input int i);
      return (i < wr_data_q.size()) ? wr_data_q[i] : -1;
   endfunction
   function automatic int rd_a(input int i);
      return (i < rd_addr_q.size()) ? rd_addr_q[i] : -1;
   endfunction

   task automatic clr();
      @(posedge clk);
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      err_cnt = 0; saw_active = 0; saw_oe = 0;
      @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_sdq0 = mo[i];
         repeat (half) @(negedge clk);
         mi[i] = spi_sdq1;
         spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic spi_frame(input int nb, input int extra);
      logic [7:0] r;
      spi_scs = 1'b0;
      repeat (half) @(negedge clk);
      for (int b = 0; b < nb; b++) begin
         spi_bits(mosi[b], 8, r);
         miso[b] = r;
      end
      if (extra > 0) spi_bits(mosi[nb], extra, r);
      repeat (half) @(negedge clk);
      spi_scs  = 1'b1;
      spi_sdq0 = 1'b0;
      repeat (2 * half) @(negedge clk);
   endtask

   initial begin
      logic [7:0] r, e;
      int rw, a, len;

      repeat (3) @(negedge clk);
      chk("rst_outs_held", 32'(outs), 32'h0);
      rstnn = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_outs_released", 32'(outs), 32'h0);

      // Write burst
      clr(); sdq1_must_be_zero = 1;
      mosi[0] = 8'h05; mosi[1] = 8'hA5; mosi[2] = 8'h3C;
      spi_frame(3, 0);
      sdq1_must_be_zero = 0;
      chk("wr_count", wr_addr_q.size(), 2);
      chk("wr0_addr", wr_a(0), 5);  chk("wr0_data", wr_d(0), 'hA5);
      chk("wr1_addr", wr_a(1), 6);  chk("wr1_data", wr_d(1), 'h3C);
      chk("wr_no_rden", rd_addr_q.size(), 0);
      chk("wr_no_err", err_cnt, 0);
      chk("wr_sdq1_zero", sdq1_bad, 0);
      chk("wr_saw_active", saw_active, 1);
      chk("wr_saw_oe", saw_oe, 1);
      chk("wr_idle_after", frame_active, 0);

      // Read burst
      clr();
      mosi[0] = 8'h90; mosi[1] = 8'h00; mosi[2] = 8'h00;
      spi_frame(3, 0);
      chk("rd_miso0", miso[1], 'h21);
      chk("rd_miso1", miso[2], 'h23);
      chk("rd_count", rd_addr_q.size(), 3);
      chk("rd_addr0", rd_a(0), 'h10);
      chk("rd_addr1", rd_a(1), 'h11);
      chk("rd_addr2", rd_a(2), 'h12);
      chk("rd_no_wren", wr_addr_q.size(), 0);

      // Address wrap
      clr();
      mosi[0] = 8'h7F; mosi[1] = 8'h11; mosi[2] = 8'h22;
      spi_frame(3, 0);
      chk("wrap_addr0", wr_a(0), 'h7F); chk("wrap_data0", wr_d(0), 'h11);
      chk("wrap_addr1", wr_a(1), 'h00); chk("wrap_data1", wr_d(1), 'h22);
      chk("wrap_no_err", err_cnt, 0);

      // Abort with a partial byte, then a clean frame
      clr();
      mosi[0] = 8'h02; mosi[1] = 8'h55; mosi[2] = 8'hF0;
      spi_frame(2, 5);
      chk("abort_wr_count", wr_addr_q.size(), 1);
      chk("abort_wr_addr", wr_a(0), 2); chk("abort_wr_data", wr_d(0), 'h55);
      chk("abort_err", err_cnt, 1);
      chk("abort_idle", frame_active, 0);
      clr();
      mosi[0] = 8'h03; mosi[1] = 8'h66;
      spi_frame(2, 0);
      chk("post_abort_addr", wr_a(0), 3); chk("post_abort_data", wr_d(0), 'h66);
      chk("post_abort_count", wr_addr_q.size(), 1);
      chk("post_abort_no_err", err_cnt, 0);

      // Reset mid-read with scs held low across release
      clr();
      spi_scs = 1'b0;
      repeat (half) @(negedge clk);
      spi_bits(8'h90, 8, r);
      spi_bits(8'h00, 3, r);
      rstnn = 1'b0;
      #1;
      chk("rst_mid_outs", 32'(outs), 32'h0);
      repeat (4) @(negedge clk);
      rstnn = 1'b1;
      clr();
      repeat (10) @(negedge clk);
      chk("rst_rel_outs", 32'(outs), 32'h0);
      spi_bits(8'h05, 8, r);
      spi_bits(8'hA5, 8, r);
      chk("rst_no_wren", wr_addr_q.size(), 0);
      chk("rst_no_rden", rd_addr_q.size(), 0);
      chk("rst_never_active", saw_active, 0);
      chk("rst_no_oe", saw_oe, 0);
      spi_scs = 1'b1;
      repeat (2 * half) @(negedge clk);
      clr();
      mosi[0] = 8'h01; mosi[1] = 8'h77;
      spi_frame(2, 0);
      chk("rst_rearm_addr", wr_a(0), 1); chk("rst_rearm_data", wr_d(0), 'h77);

      // Back-to-back random bursts at sclk = clk/8
      half = 4;
      for (int f = 0; f < 24; f++) begin
         rw  = $urandom_range(0, 1);
         a   = $urandom_range(0, 127);
         len = $urandom_range(1, 4);
         mosi[0] = {rw[0], a[6:0]};
         for (int i = 1; i <= len; i++) mosi[i] = 8'($urandom);
         clr();
         sdq1_must_be_zero = (rw == 0);
         spi_frame(len + 1, 0);
         sdq1_must_be_zero = 0;
         if (rw == 1) begin
            chk("st_rd_count", rd_addr_q.size(), len + 1);
            chk("st_rd_no_wren", wr_addr_q.size(), 0);
            for (int i = 0; i <= len; i++) chk("st_rd_addr", rd_a(i), (a + i) % 128);
            for (int i = 1; i <= len; i++) begin
               e = 8'(((a + i - 1) % 128) * 2 + 1);
               chk("st_miso", miso[i], e);
            end
         end else begin
            chk("st_wr_count", wr_addr_q.size(), len);
            chk("st_wr_no_rden", rd_addr_q.size(), 0);
            for (int i = 0; i < len; i++) begin
               chk("st_wr_addr", wr_a(i), (a + i) % 128);
               chk("st_wr_data", wr_d(i), int'(mosi[i + 1]));
            end
         end
         chk("st_no_err", err_cnt, 0);
      end
      chk("st_sdq1_zero", sdq1_bad, 0);
      chk("no_dual_strobe", both_cnt, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
